// File: rtl/cpu_trace_pkg.sv
// Shared types and width helpers for the retire-trace capture unit.
package cpu_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  typedef enum logic {
    MODE_STOP = 1'b0,
    MODE_WRAP = 1'b1
  } mode_e;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace sample storage: one synchronous write port, one asynchronous read port.
module trace_ram
  import cpu_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [ptr_width(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]            wdata,
  input  logic [ptr_width(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]            rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // sample write; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/cpu_trace_buffer.sv
// Retire-trace capture: PC-triggered sampling of {PC, instr} into a ring
// buffer with stop-on-full or wrap modes, drained over a valid/ready port.
module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int ILEN  = 32,
  parameter int DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [XLEN+ILEN-1:0]          debug_in,
  input  logic                          valid_in,
  input  logic                          arm,
  input  logic                          mode,
  input  logic                          trig_en,
  input  logic [XLEN-1:0]               trig_pc,
  input  logic                          stop,
  input  logic                          rd_ready,
  output logic                          rd_valid,
  output logic [XLEN+ILEN-1:0]          rd_data,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic [1:0]                    state_o,
  output logic                          triggered,
  output logic                          overflow
);

  localparam int DW = XLEN + ILEN;
  localparam int PW = ptr_width(DEPTH);
  localparam int CW = count_width(DEPTH);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_ZERO = PW'(0);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  state_e          state_r, state_s;
  mode_e           mode_r, mode_s;
  logic [PW-1:0]   wr_ptr_r, wr_ptr_s, rd_ptr_r, rd_ptr_s;
  logic [CW-1:0]   count_r, count_s;
  logic            triggered_r, triggered_s;
  logic            overflow_r, overflow_s;
  // remembers that STOP mode ended capture by filling, so late samples count as drops
  logic            full_done_r, full_done_s;
  logic            wr_en_s, hit_s, rd_fire_s;

  assign hit_s     = valid_in && (!trig_en || (debug_in[DW-1:ILEN] == trig_pc));
  assign rd_valid  = (state_r == ST_DONE) && (count_r != CNT_ZERO);
  assign rd_fire_s = rd_valid && rd_ready;

  // next-state, pointer and flag logic; priority arm > stop > write > read
  always_comb begin
    state_s     = state_r;
    mode_s      = mode_r;
    wr_ptr_s    = wr_ptr_r;
    rd_ptr_s    = rd_ptr_r;
    count_s     = count_r;
    triggered_s = triggered_r;
    overflow_s  = overflow_r;
    full_done_s = full_done_r;
    wr_en_s     = 1'b0;
    if (arm) begin
      state_s     = ST_ARMED;
      mode_s      = mode ? MODE_WRAP : MODE_STOP;
      wr_ptr_s    = PTR_ZERO;
      rd_ptr_s    = PTR_ZERO;
      count_s     = CNT_ZERO;
      triggered_s = 1'b0;
      overflow_s  = 1'b0;
      full_done_s = 1'b0;
    end else if (stop && ((state_r == ST_ARMED) || (state_r == ST_CAPTURE))) begin
      state_s = ST_DONE;
    end else begin
      case (state_r)
        ST_ARMED: begin
          if (hit_s) begin
            wr_en_s     = 1'b1;
            wr_ptr_s    = wr_ptr_r + PTR_ONE;
            count_s     = count_r + CNT_ONE;
            triggered_s = 1'b1;
            state_s     = ST_CAPTURE;
          end else begin
            state_s = ST_ARMED;
          end
        end
        ST_CAPTURE: begin
          if (valid_in && (count_r != CNT_FULL)) begin
            wr_en_s  = 1'b1;
            wr_ptr_s = wr_ptr_r + PTR_ONE;
            count_s  = count_r + CNT_ONE;
            if ((mode_r == MODE_STOP) && (count_r == (CNT_FULL - CNT_ONE))) begin
              state_s     = ST_DONE;
              full_done_s = 1'b1;
            end else begin
              state_s = ST_CAPTURE;
            end
          end else if (valid_in && (mode_r == MODE_WRAP)) begin
            // full ring: newest sample replaces oldest
            wr_en_s    = 1'b1;
            wr_ptr_s   = wr_ptr_r + PTR_ONE;
            rd_ptr_s   = rd_ptr_r + PTR_ONE;
            overflow_s = 1'b1;
          end else if (valid_in) begin
            overflow_s = 1'b1;
          end else begin
            wr_en_s = 1'b0;
          end
        end
        ST_DONE: begin
          if (valid_in && (mode_r == MODE_STOP) && full_done_r) begin
            overflow_s = 1'b1;
          end else begin
            overflow_s = overflow_r;
          end
          if (rd_fire_s) begin
            rd_ptr_s = rd_ptr_r + PTR_ONE;
            count_s  = count_r - CNT_ONE;
          end else begin
            rd_ptr_s = rd_ptr_r;
          end
        end
        ST_IDLE: begin
          state_s = ST_IDLE;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // control registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      mode_r      <= MODE_STOP;
      wr_ptr_r    <= PTR_ZERO;
      rd_ptr_r    <= PTR_ZERO;
      count_r     <= CNT_ZERO;
      triggered_r <= 1'b0;
      overflow_r  <= 1'b0;
      full_done_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      mode_r      <= mode_s;
      wr_ptr_r    <= wr_ptr_s;
      rd_ptr_r    <= rd_ptr_s;
      count_r     <= count_s;
      triggered_r <= triggered_s;
      overflow_r  <= overflow_s;
      full_done_r <= full_done_s;
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (DW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en_s),
    .waddr (wr_ptr_r),
    .wdata (debug_in),
    .raddr (rd_ptr_r),
    .rdata (rd_data)
  );

  assign count     = count_r;
  assign state_o   = state_r;
  assign triggered = triggered_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Self-checking bench for cpu_trace_buffer: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_cpu_trace_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] debug_in = 64'd0;
  logic        valid_in = 1'b0;
  logic        arm = 1'b0;
  logic        mode = 1'b0;
  logic        trig_en = 1'b0;
  logic [31:0] trig_pc = 32'd0;
  logic        stop = 1'b0;
  logic        rd_ready = 1'b0;
  logic        rd_valid;
  logic [63:0] rd_data;
  logic [4:0]  count;
  logic [1:0]  state_o;
  logic        triggered;
  logic        overflow;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  cpu_trace_buffer #(.XLEN(32), .ILEN(32), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .debug_in(debug_in), .valid_in(valid_in), .arm(arm),
    .mode(mode), .trig_en(trig_en), .trig_pc(trig_pc), .stop(stop),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .count(count),
    .state_o(state_o), .triggered(triggered), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // reference model: state 0..3, queue of held entries (front = oldest)
  int          m_state = 0;
  bit          m_mode = 1'b0;
  bit          m_trig = 1'b0;
  bit          m_ovf = 1'b0;
  bit          m_full_done = 1'b0;
  logic [63:0] mq[$];

  always @(posedge clk) begin
    if (!rst) begin
      m_state = 0; m_mode = 1'b0; m_trig = 1'b0; m_ovf = 1'b0; m_full_done = 1'b0;
      mq.delete();
    end else if (arm) begin
      m_state = 1; m_mode = mode; m_trig = 1'b0; m_ovf = 1'b0; m_full_done = 1'b0;
      mq.delete();
    end else if (stop && (m_state == 1 || m_state == 2)) begin
      m_state = 3;
    end else if (m_state == 1) begin
      if (valid_in && (!trig_en || debug_in[63:32] == trig_pc)) begin
        mq.push_back(debug_in);
        m_trig = 1'b1;
        m_state = 2;
      end
    end else if (m_state == 2) begin
      if (valid_in) begin
        if (mq.size() == 16) begin
          void'(mq.pop_front());
          mq.push_back(debug_in);
          m_ovf = 1'b1;
        end else begin
          mq.push_back(debug_in);
          if (!m_mode && mq.size() == 16) begin
            m_state = 3;
            m_full_done = 1'b1;
          end
        end
      end
    end else if (m_state == 3) begin
      if (valid_in && !m_mode && m_full_done) m_ovf = 1'b1;
      if (mq.size() != 0 && rd_ready) void'(mq.pop_front());
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", 64'(state_o), 64'(m_state));
      chk("count", 64'(count), 64'(mq.size()));
      chk("triggered", 64'(triggered), 64'(m_trig));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("rd_valid", 64'(rd_valid), 64'(m_state == 3 && mq.size() != 0));
      if (m_state == 3 && mq.size() != 0) chk("rd_data", rd_data, mq[0]);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic sample(input logic [31:0] pc);
    debug_in = {pc, $urandom};
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
  endtask

  task automatic do_arm(input logic m, input logic te, input logic [31:0] tp);
    mode = m; trig_en = te; trig_pc = tp;
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  initial begin
    int reads;
    logic [63:0] first_s;

    // 1: reset with valid_in toggling
    rst = 1'b0;
    valid_in = 1'b1; step();
    valid_in = 1'b0; step();
    chk_en = 1'b1;
    chk("t1 state", 64'(state_o), 64'd0);
    chk("t1 count", 64'(count), 64'd0);
    chk("t1 rd_valid", 64'(rd_valid), 64'd0);
    chk("t1 triggered", 64'(triggered), 64'd0);
    chk("t1 overflow", 64'(overflow), 64'd0);
    rst = 1'b1;
    step();

    // 2: STOP mode, PC trigger at 0x10, fill, then one more sample
    do_arm(1'b0, 1'b1, 32'h10);
    for (int k = 0; k <= 20; k++) sample(32'(k * 4));
    chk("t2 state", 64'(state_o), 64'd3);
    chk("t2 count", 64'(count), 64'd16);
    chk("t2 triggered", 64'(triggered), 64'd1);
    chk("t2 overflow", 64'(overflow), 64'd1);
    chk("t2 first pc", 64'(rd_data[63:32]), 64'h10);

    // 3: WRAP, 20 samples, newest 16 kept
    do_arm(1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 20; k++) sample(32'h100 + 32'(k * 4));
    do_stop();
    chk("t3 count", 64'(count), 64'd16);
    chk("t3 overflow", 64'(overflow), 64'd1);
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t3 drain pc", 64'(rd_data[63:32]), 64'(32'h110 + 32'(i * 4)));
      step();
    end
    rd_ready = 1'b0;
    chk("t3 rd_valid", 64'(rd_valid), 64'd0);
    chk("t3 count end", 64'(count), 64'd0);

    // 4: stop coincident with valid_in; drain with toggling ready
    do_arm(1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 5; k++) sample(32'h200 + 32'(k * 4));
    debug_in = {32'h214, 32'h0};
    valid_in = 1'b1; stop = 1'b1;
    step();
    valid_in = 1'b0; stop = 1'b0;
    chk("t4 count", 64'(count), 64'd5);
    reads = 0;
    for (int i = 0; i < 20; i++) begin
      rd_ready = (i % 2 == 0);
      if (rd_valid && rd_ready) begin
        chk("t4 drain pc", 64'(rd_data[63:32]), 64'(32'h200 + 32'(reads * 4)));
        reads++;
      end
      step();
    end
    rd_ready = 1'b0;
    chk("t4 reads", 64'(reads), 64'd5);

    // 5: reset mid-capture, then re-arm with fresh pointers
    do_arm(1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 7; k++) sample(32'h300 + 32'(k * 4));
    chk("t5 count pre", 64'(count), 64'd7);
    rst = 1'b0; step(); rst = 1'b1;
    chk("t5 state", 64'(state_o), 64'd0);
    chk("t5 count", 64'(count), 64'd0);
    do_arm(1'b0, 1'b0, 32'h0);
    first_s = {32'h400, $urandom};
    debug_in = first_s; valid_in = 1'b1; step(); valid_in = 1'b0;
    do_stop();
    chk("t5 first read", rd_data, first_s);

    // 6: re-arm from DONE with entries held
    do_arm(1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) sample(32'h500 + 32'(k * 4));
    do_stop();
    chk("t6 count pre", 64'(count), 64'd3);
    do_arm(1'b0, 1'b0, 32'h0);
    chk("t6 state", 64'(state_o), 64'd1);
    chk("t6 count", 64'(count), 64'd0);
    chk("t6 triggered", 64'(triggered), 64'd0);
    chk("t6 overflow", 64'(overflow), 64'd0);

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom % 200) != 0;
      arm      = ($urandom % 40) == 0;
      stop     = ($urandom % 30) == 0;
      mode     = $urandom % 2;
      trig_en  = $urandom % 2;
      trig_pc  = 32'(($urandom % 8) * 4);
      debug_in = {32'(($urandom % 8) * 4), $urandom};
      valid_in = $urandom % 2;
      rd_ready = $urandom % 2;
      step();
    end
    rst = 1'b1; arm = 1'b0; stop = 1'b0; valid_in = 1'b0; rd_ready = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
